fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 28, width of FIFO word and output data.
REQ-002 Parameter ROW_LEN, default 46, words per row.
REQ-003 Parameter ROW_NUM, default 46, rows per frame.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  frame start request, sampled only in IDLE.
REQ-007 fifo_empty  input  1  empty flag of the upstream synchronous FIFO.
REQ-008 fifo_rd_en  output  1  pop request to the upstream FIFO.
REQ-009 fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop.
REQ-010 m_valid  output  1  output word available.
REQ-011 m_ready  input  1  downstream accepts word.
REQ-012 m_data  output  DATA_WIDTH  output word.
REQ-013 m_last_row  output  1  current m_data is the last word of a row.
REQ-014 m_last_frame  output  1  current m_data is the last word of the frame.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse after the last frame word transfers.

Function
REQ-017 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on transfer of the frame's last word; DONE->IDLE unconditionally after one cycle.
REQ-018 done is high exactly in DONE; start in RUN or DONE is ignored.
REQ-019 Accepted pop = fifo_rd_en high in a cycle; fifo_rd_en is high only when state RUN, !fifo_empty, issued < ROW_LEN*ROW_NUM, and (buf_cnt + pending) < 3.
REQ-020 fifo_rd_en never asserts while fifo_empty is high (no pop-on-empty requests).
REQ-021 pending: 1-bit register set on an accepted pop, cleared otherwise; when pending is high, fifo_data is written into a 3-entry in-order output buffer at that edge.
REQ-022 issued: counter of accepted pops, cleared on start; no pop is issued once issued equals ROW_LEN*ROW_NUM.
REQ-023 m_valid = buffer non-empty; m_data = oldest buffer entry; transfer = m_valid && m_ready.
REQ-024 While m_valid && !m_ready, m_data, m_last_row and m_last_frame hold stable.
REQ-025 Simultaneous capture and transfer in one cycle: buf_cnt unchanged, order preserved.
REQ-026 Latency: start sampled at edge E0; first fifo_rd_en in cycle after E0 (if FIFO non-empty); first m_valid two cycles after that pop.
REQ-027 Throughput: with FIFO never empty and m_ready held high, one transfer per cycle in steady state.
REQ-028 col counter 0..ROW_LEN-1 and row counter 0..ROW_NUM-1 advance on each transfer; col wraps to 0 and row increments at ROW_LEN-1.
REQ-029 m_last_row = m_valid && col==ROW_LEN-1; m_last_frame = m_last_row && row==ROW_NUM-1.
REQ-030 Counter widths: issued ceil(log2(ROW_LEN*ROW_NUM+1)) bits, col/row ceil(log2) of their ranges; no overflow permitted.
REQ-031 FIFO empty mid-frame: pops stall, buffer drains, m_valid drops; resumes without loss or duplication when fifo_empty falls.
REQ-032 m_ready low: buffer fills to 3 and pops stop; no word dropped.

Reset
REQ-033 rst_n low: state IDLE, fifo_rd_en, m_valid, m_last_row, m_last_frame, busy, done = 0, m_data = 0, all counters and pending = 0, buffer empty, immediately and asynchronously.
REQ-034 Reset mid-frame: in-flight and buffered words are discarded; after release, block waits in IDLE for start.

Verification (ROW_LEN=4, ROW_NUM=2)
REQ-035 FIFO preloaded 0..7, m_ready=1, start pulse -> 8 pops, m_data 0..7 in order, last_row on 3 and 7, last_frame on 7, done one cycle after 7 transfers, fifo_rd_en never 9 times.
REQ-036 FIFO holds 0..2, word 3..7 written one every 5 cycles -> fifo_rd_en never high with fifo_empty, m_valid gaps, output 0..7 exact.
REQ-037 m_ready low for 10 cycles after start with full FIFO -> exactly 3 pops, m_data=0 stable, then 0..7 on release.
REQ-038 m_ready toggling 1,0,1,0 -> no loss/duplication, flags align with words 3 and 7.
REQ-039 rst_n asserted after 4th transfer -> all outputs 0 same cycle; new start after release -> col/row restart at 0.
REQ-040 start pulsed during RUN and DONE -> ignored; frame count and done pulses equal 1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pops a frame of ROW_LEN*ROW_NUM words from a synchronous FIFO and streams them out
// through a 3-entry buffer with valid/ready handshake and row/frame end markers.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | popping FIFO and streaming words
//   S_DONE | one-cycle completion pulse
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 28,
   parameter int ROW_LEN    = 46,
   parameter int ROW_NUM    = 46
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last_row,
   output logic                  m_last_frame,
   output logic                  busy,
   output logic                  done
);

   localparam int TOTAL = ROW_LEN * ROW_NUM;
   localparam int ISS_W = $clog2(TOTAL + 1);
   localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ISS_W-1:0]      r_issued;
   logic                  r_pending;
   logic [DATA_WIDTH-1:0] r_buf [0:2];
   logic [1:0]            r_cnt;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;

   logic                  w_start;
   logic                  w_xfer;
   logic                  w_col_last;
   logic                  w_row_last;
   logic [1:0]            w_wr_idx;

   assign w_start    = (r_state == S_IDLE) && start;
   assign w_xfer     = m_valid && m_ready;
   assign w_col_last = (r_col == COL_W'(ROW_LEN - 1));
   assign w_row_last = (r_row == ROW_W'(ROW_NUM - 1));
   // captured word lands behind whatever survives this cycle's transfer
   assign w_wr_idx   = r_cnt - {1'b0, w_xfer};

   assign fifo_rd_en   = (r_state == S_RUN) && !fifo_empty &&
                         (r_issued < ISS_W'(TOTAL)) &&
                         (({1'b0, r_cnt} + {2'b00, r_pending}) < 3'd3);
   assign m_valid      = (r_cnt != 2'd0);
   assign m_data       = r_buf[0];
   assign m_last_row   = m_valid && w_col_last;
   assign m_last_frame = m_last_row && w_row_last;
   assign busy         = (r_state == S_RUN);
   assign done         = (r_state == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_xfer && m_last_frame) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issued  <= '0;
         r_pending <= 1'b0;
      end else begin
         r_pending <= fifo_rd_en;
         if (w_start) begin
            r_issued <= '0;
         end else if (fifo_rd_en) begin
            r_issued <= r_issued + 1'b1;
         end
      end
   end

   // pop-gating on cnt+pending guarantees a capture never finds the buffer full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) r_buf[i] <= '0;
         r_cnt <= 2'd0;
      end else begin
         if (w_xfer) begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= r_buf[2];
         end
         for (int i = 0; i < 3; i++) begin
            if (r_pending && (w_wr_idx == 2'(i))) r_buf[i] <= fifo_data;
         end
         r_cnt <= r_cnt + {1'b0, r_pending} - {1'b0, w_xfer};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_xfer) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a 4x2 frame and a behavioural synchronous FIFO.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [27:0] fifo_data = '0;
   logic        m_valid;
   logic        m_ready;
   logic [27:0] m_data;
   logic        m_last_row;
   logic        m_last_frame;
   logic        busy;
   logic        done;

   int n_chk = 0;
   int n_err = 0;

   fifo_stream_reader #(.DATA_WIDTH(28), .ROW_LEN(4), .ROW_NUM(2)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_data    (fifo_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last_row   (m_last_row),
      .m_last_frame (m_last_frame),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // synchronous FIFO model: read data registered on an accepted pop
   logic [27:0] mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        fifo_flush = 1'b0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_flush) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd_en && !fifo_empty) begin
         fifo_data <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // monitor on the falling edge
   int          cyc = 0;
   logic [27:0] oq_d [$];
   logic        oq_lr [$];
   logic        oq_lf [$];
   int          xq_cyc [$];
   int          pop_cnt = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          bad_pop = 0;
   int          hold_bad = 0;
   int          gap_cnt = 0;
   int          first_rd_cyc = -1;
   int          first_v_cyc = -1;
   logic        prev_stall = 1'b0;
   logic [27:0] prev_d = '0;
   logic        prev_lr = 1'b0;
   logic        prev_lf = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (fifo_rd_en) pop_cnt = pop_cnt + 1;
      if (fifo_rd_en && fifo_empty) bad_pop = bad_pop + 1;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (busy && !m_valid) gap_cnt = gap_cnt + 1;
      if (fifo_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (m_valid && m_ready) begin
         oq_d.push_back(m_data);
         oq_lr.push_back(m_last_row);
         oq_lf.push_back(m_last_frame);
         xq_cyc.push_back(cyc);
      end
      if (rst_n && prev_stall &&
          (m_data != prev_d || m_last_row != prev_lr || m_last_frame != prev_lf))
         hold_bad = hold_bad + 1;
      prev_stall = rst_n && m_valid && !m_ready;
      prev_d     = m_data;
      prev_lr    = m_last_row;
      prev_lf    = m_last_frame;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int v);
      mem[wr_ptr % 256] = 28'(v);
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic flush();
      fifo_flush = 1'b1;
      tick();
      fifo_flush = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base, input int lim);
      int k;
      k = 0;
      while (done_cnt == base && k < lim) begin
         tick();
         k++;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt > base), 32'd1);
   endtask

   // expected frame: words 0..7, row end on 3 and 7, frame end on 7
   task automatic check_stream(input string tag, input int base);
      chk({tag, "_count"}, 32'(oq_d.size() - base), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < oq_d.size()) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(oq_d[base+i]), 32'(i));
            chk($sformatf("%s_lrow%0d", tag, i), 32'(oq_lr[base+i]), 32'((i % 4) == 3));
            chk($sformatf("%s_lfrm%0d", tag, i), 32'(oq_lf[base+i]), 32'(i == 7));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int base, pb, db, gb, s_cyc, k;

      rst_n   = 1'b0;
      start   = 1'b0;
      m_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_data",  32'(m_data), 32'd0);
      rst_n = 1'b1;
      tick();

      // basic frame, full FIFO, ready high
      base = oq_d.size(); pb = pop_cnt; db = done_cnt; gb = gap_cnt;
      for (int v = 0; v < 8; v++) push(v);
      tick();
      s_cyc = cyc;
      pulse_start();
      wait_done("t1", db, 60);
      tick();
      check_stream("t1", base);
      chk("t1_pops", 32'(pop_cnt - pb), 32'd8);
      chk("t1_done_pulses", 32'(done_cnt - db), 32'd1);
      chk("t1_done_timing", 32'(done_cyc), 32'(xq_cyc[xq_cyc.size()-1] + 1));
      chk("t1_first_pop", 32'(first_rd_cyc), 32'(s_cyc + 2));
      chk("t1_first_valid", 32'(first_v_cyc - first_rd_cyc), 32'd2);
      chk("t1_gaps", 32'(gap_cnt - gb), 32'd2);

      // FIFO trickle: starts with 3 words, one more every 5 cycles
      flush();
      base = oq_d.size(); gb = gap_cnt; db = done_cnt;
      for (int v = 0; v < 3; v++) push(v);
      pulse_start();
      for (int v = 3; v < 8; v++) begin
         repeat (5) tick();
         push(v);
      end
      wait_done("t2", db, 60);
      tick();
      check_stream("t2", base);
      chk("t2_gaps_seen", 32'((gap_cnt - gb) > 2), 32'd1);

      // backpressure: ready low for 10 cycles
      flush();
      base = oq_d.size(); pb = pop_cnt; db = done_cnt;
      for (int v = 0; v < 8; v++) push(v);
      m_ready = 1'b0;
      pulse_start();
      repeat (10) tick();
      chk("t3_pops_stalled", 32'(pop_cnt - pb), 32'd3);
      chk("t3_valid", 32'(m_valid), 32'd1);
      chk("t3_data_head", 32'(m_data), 32'd0);
      m_ready = 1'b1;
      wait_done("t3", db, 60);
      tick();
      check_stream("t3", base);
      chk("t3_pops", 32'(pop_cnt - pb), 32'd8);

      // ready toggling every cycle
      flush();
      base = oq_d.size(); db = done_cnt;
      for (int v = 0; v < 8; v++) push(v);
      pulse_start();
      k = 0;
      while (done_cnt == db && k < 80) begin
         m_ready = !m_ready;
         tick();
         k++;
      end
      m_ready = 1'b1;
      chk("t4_done_seen", 32'(done_cnt > db), 32'd1);
      tick();
      check_stream("t4", base);

      // reset after the fourth transfer
      flush();
      base = oq_d.size();
      for (int v = 0; v < 8; v++) push(v);
      pulse_start();
      k = 0;
      while ((oq_d.size() - base) < 4 && k < 40) begin
         tick();
         k++;
      end
      chk("t5_four_xfers", 32'(oq_d.size() - base), 32'd4);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(m_valid), 32'd0);
      chk("t5_rst_data",  32'(m_data), 32'd0);
      chk("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t5_rst_busy",  32'(busy), 32'd0);
      chk("t5_rst_done",  32'(done), 32'd0);
      chk("t5_rst_lrow",  32'(m_last_row), 32'd0);
      chk("t5_rst_lfrm",  32'(m_last_frame), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      flush();
      for (int v = 0; v < 8; v++) push(v);
      repeat (3) tick();
      chk("t5_idle_wait", 32'(busy), 32'd0);
      chk("t5_no_pop_idle", 32'(fifo_rd_en), 32'd0);
      base = oq_d.size(); db = done_cnt;
      pulse_start();
      wait_done("t5", db, 60);
      tick();
      check_stream("t5", base);

      // start pulses during RUN and DONE must be ignored
      flush();
      base = oq_d.size(); pb = pop_cnt; db = done_cnt;
      for (int v = 0; v < 8; v++) push(v);
      pulse_start();
      repeat (3) tick();
      pulse_start();
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk("t6_in_done", 32'(done), 32'd1);
      pulse_start();
      repeat (10) tick();
      chk("t6_done_pulses", 32'(done_cnt - db), 32'd1);
      chk("t6_pops", 32'(pop_cnt - pb), 32'd8);
      chk("t6_idle", 32'(busy), 32'd0);
      check_stream("t6", base);

      chk("no_pop_on_empty", 32'(bad_pop), 32'd0);
      chk("hold_stable", 32'(hold_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
